// File: rtl/spm_dp.sv
`default_nettype none
// ============================================================================
// Module      : spm_dp
// Description : Dual-port scratch-pad memory with byte-enable writes, a 1- or
//               2-cycle read pipeline, same-address collision rules and a
//               post-reset zero-fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
module spm_dp #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int INIT_ZERO = 1,
  parameter int FWD       = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // port A (instruction fetch)
  input  logic                  a_as_,
  input  logic                  a_rw,
  input  logic [ADDR_W-1:0]     a_addr,
  input  logic [DATA_W/8-1:0]   a_be,
  input  logic [DATA_W-1:0]     a_wr_data,
  output logic [DATA_W-1:0]     a_rd_data,
  output logic                  a_rd_vld,
  // port B (memory stage)
  input  logic                  b_as_,
  input  logic                  b_rw,
  input  logic [ADDR_W-1:0]     b_addr,
  input  logic [DATA_W/8-1:0]   b_be,
  input  logic [DATA_W-1:0]     b_wr_data,
  output logic [DATA_W-1:0]     b_rd_data,
  output logic                  b_rd_vld,
  output logic                  busy
);

  localparam int   DEPTH   = 2 ** ADDR_W;
  localparam int   BE_W    = DATA_W / 8;
  localparam logic RW_READ = 1'b1;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   fill_cnt;
  logic                fill_we;

  logic [DATA_W-1:0]   mem [DEPTH];

  logic                a_acc, b_acc;
  logic                a_rd, a_wr, b_rd, b_wr;
  logic                same_addr;
  logic [DATA_W-1:0]   a_merged, b_merged, b_base;
  logic [DATA_W-1:0]   a_rd_word, b_rd_word;

  // FSM state register; reset chooses between fill and direct service
  always_ff @(posedge clk) begin
    if (!rst_n) state <= (INIT_ZERO != 0) ? ST_INIT : ST_RUN;
    else        state <= state_nxt;
  end

  // Fill counter walks every word once while in INIT
  always_ff @(posedge clk) begin
    if (!rst_n)                fill_cnt <= '0;
    else if (state == ST_INIT) fill_cnt <= fill_cnt + 1'b1;
  end

  // Next-state and fill control; RUN is only left through reset
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    fill_we   = 1'b0;
    if (state == ST_INIT) begin
      busy    = 1'b1;
      fill_we = rst_n;
      if (fill_cnt == {ADDR_W{1'b1}}) state_nxt = ST_RUN;
    end
  end

  // Acceptance: strobe low, not filling, and not a reset edge
  always_comb begin
    a_acc     = rst_n && !a_as_ && !busy;
    b_acc     = rst_n && !b_as_ && !busy;
    a_rd      = a_acc && (a_rw == RW_READ);
    a_wr      = a_acc && (a_rw != RW_READ);
    b_rd      = b_acc && (b_rw == RW_READ);
    b_wr      = b_acc && (b_rw != RW_READ);
    same_addr = (a_addr == b_addr);
  end

  // Post-write words per port; B is layered on top of A so B wins shared bytes
  always_comb begin
    a_merged = mem[a_addr];
    for (int i = 0; i < BE_W; i++) begin
      if (a_be[i]) a_merged[8*i +: 8] = a_wr_data[8*i +: 8];
    end
    b_base   = (a_wr && same_addr) ? a_merged : mem[b_addr];
    b_merged = b_base;
    for (int i = 0; i < BE_W; i++) begin
      if (b_be[i]) b_merged[8*i +: 8] = b_wr_data[8*i +: 8];
    end
  end

  // Read words; a reader sees the other port's write only when forwarding
  always_comb begin
    a_rd_word = mem[a_addr];
    b_rd_word = mem[b_addr];
    if (FWD != 0 && b_wr && same_addr) a_rd_word = b_merged;
    if (FWD != 0 && a_wr && same_addr) b_rd_word = a_merged;
  end

  // Array writes: zero-fill while busy, otherwise the two ports
  always_ff @(posedge clk) begin
    if (fill_we) mem[fill_cnt] <= '0;
    if (a_wr)    mem[a_addr]   <= a_merged;
    if (b_wr)    mem[b_addr]   <= b_merged;
  end

  if (RD_LAT == 1) begin : g_lat1
    // Single read register stage; data holds when no read completes
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_rd_vld  <= 1'b0;
        a_rd_data <= '0;
        b_rd_vld  <= 1'b0;
        b_rd_data <= '0;
      end else begin
        a_rd_vld <= a_rd;
        b_rd_vld <= b_rd;
        if (a_rd) a_rd_data <= a_rd_word;
        if (b_rd) b_rd_data <= b_rd_word;
      end
    end
  end else begin : g_lat2
    logic              a_p_vld, b_p_vld;
    logic [DATA_W-1:0] a_p_data, b_p_data;

    // Two read register stages; reset drops anything still in the pipe
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        a_p_vld   <= 1'b0;
        a_p_data  <= '0;
        b_p_vld   <= 1'b0;
        b_p_data  <= '0;
        a_rd_vld  <= 1'b0;
        a_rd_data <= '0;
        b_rd_vld  <= 1'b0;
        b_rd_data <= '0;
      end else begin
        a_p_vld  <= a_rd;
        b_p_vld  <= b_rd;
        if (a_rd) a_p_data <= a_rd_word;
        if (b_rd) b_p_data <= b_rd_word;
        a_rd_vld <= a_p_vld;
        b_rd_vld <= b_p_vld;
        if (a_p_vld) a_rd_data <= a_p_data;
        if (b_p_vld) b_rd_data <= b_p_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_spm_dp.sv
`default_nettype none
// ============================================================================
// Module      : tb_spm_dp
// Description : Scoreboard bench for spm_dp. Two instances share stimulus:
//               dut1 (RD_LAT=1, FWD=1) and dut2 (RD_LAT=2, FWD=0).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spm_dp;

  localparam int AW    = 6;
  localparam int DW    = 32;
  localparam int DEPTH = 2 ** AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rst_next = 1'b0;

  logic          a_as_ = 1'b1, a_rw = 1'b1, b_as_ = 1'b1, b_rw = 1'b1;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [3:0]    a_be = '0, b_be = '0;
  logic [DW-1:0] a_wr_data = '0, b_wr_data = '0;

  logic [DW-1:0] a_rd_data1, b_rd_data1, a_rd_data2, b_rd_data2;
  logic          a_rd_vld1, b_rd_vld1, a_rd_vld2, b_rd_vld2, busy1, busy2;

  always #5 clk = ~clk;

  spm_dp #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .INIT_ZERO(1), .FWD(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .a_as_(a_as_), .a_rw(a_rw), .a_addr(a_addr), .a_be(a_be), .a_wr_data(a_wr_data),
    .a_rd_data(a_rd_data1), .a_rd_vld(a_rd_vld1),
    .b_as_(b_as_), .b_rw(b_rw), .b_addr(b_addr), .b_be(b_be), .b_wr_data(b_wr_data),
    .b_rd_data(b_rd_data1), .b_rd_vld(b_rd_vld1),
    .busy(busy1)
  );

  spm_dp #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .INIT_ZERO(1), .FWD(0)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .a_as_(a_as_), .a_rw(a_rw), .a_addr(a_addr), .a_be(a_be), .a_wr_data(a_wr_data),
    .a_rd_data(a_rd_data2), .a_rd_vld(a_rd_vld2),
    .b_as_(b_as_), .b_rw(b_rw), .b_addr(b_addr), .b_be(b_be), .b_wr_data(b_wr_data),
    .b_rd_data(b_rd_data2), .b_rd_vld(b_rd_vld2),
    .busy(busy2)
  );

  // Reference model: word array, remaining fill cycles, expected-read queues
  // q[0]=dut1 A, q[1]=dut1 B, q[2]=dut2 A, q[3]=dut2 B
  logic [DW-1:0] mem_m [DEPTH];
  logic [DW-1:0] q [4][$];
  int  fill_left = DEPTH;
  bit  started = 1'b0;
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                          input logic [3:0] be);
    logic [DW-1:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  // Model time base: reset restarts the fill, completion zeroes the array
  always @(posedge clk) begin
    if (!rst_n) begin
      started   = 1'b1;
      fill_left = DEPTH;
      for (int k = 0; k < 4; k++) q[k].delete();
    end else if (fill_left > 0) begin
      fill_left--;
      if (fill_left == 0) for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    end
  end

  task automatic pop_chk(input int k, input string name, input logic vld, input logic [DW-1:0] d);
    logic [DW-1:0] exp;
    if (vld) begin
      if (q[k].size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s unexpected vld: got data %h expected no read", name, d);
      end else begin
        exp = q[k].pop_front();
        check(name, d, exp);
      end
    end
  endtask

  // Monitor: busy against model fill state, read data against the queues
  always @(negedge clk) begin
    if (started) begin
      check("busy1", {31'b0, busy1}, {31'b0, fill_left != 0});
      check("busy2", {31'b0, busy2}, {31'b0, fill_left != 0});
      pop_chk(0, "dut1_a_rd", a_rd_vld1, a_rd_data1);
      pop_chk(1, "dut1_b_rd", b_rd_vld1, b_rd_data1);
      pop_chk(2, "dut2_a_rd", a_rd_vld2, a_rd_data2);
      pop_chk(3, "dut2_b_rd", b_rd_vld2, b_rd_data2);
    end
  end

  // One cycle of stimulus; the model decides acceptance and expected reads
  task automatic issue(input bit aen, input bit arw, input logic [AW-1:0] aad, input logic [3:0] abe,
                       input logic [DW-1:0] ad,
                       input bit ben, input bit brw, input logic [AW-1:0] bad, input logic [3:0] bbe,
                       input logic [DW-1:0] bd);
    logic [DW-1:0] old_a, old_b;
    @(negedge clk);
    rst_n = rst_next;
    a_as_ = !aen; a_rw = arw; a_addr = aad; a_be = abe; a_wr_data = ad;
    b_as_ = !ben; b_rw = brw; b_addr = bad; b_be = bbe; b_wr_data = bd;
    if (rst_n && fill_left == 0) begin
      old_a = mem_m[aad];
      old_b = mem_m[bad];
      if (aen && arw) begin
        q[0].push_back((ben && !brw && bad == aad) ? merge(old_a, bd, bbe) : old_a);
        q[2].push_back(old_a);
      end
      if (ben && brw) begin
        q[1].push_back((aen && !arw && aad == bad) ? merge(old_b, ad, abe) : old_b);
        q[3].push_back(old_b);
      end
      if (aen && !arw) mem_m[aad] = merge(mem_m[aad], ad, abe);
      if (ben && !brw) mem_m[bad] = merge(mem_m[bad], bd, bbe);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(0, 1, '0, '0, '0, 0, 1, '0, '0, '0);
  endtask

  task automatic rd_a(input logic [AW-1:0] ad);
    issue(1, 1, ad, '0, '0, 0, 1, '0, '0, '0);
  endtask

  task automatic wr_a(input logic [AW-1:0] ad, input logic [DW-1:0] d, input logic [3:0] be);
    issue(1, 0, ad, be, d, 0, 1, '0, '0, '0);
  endtask

  initial begin
    // Reset and reset-state outputs
    rst_next = 1'b0;
    idle(3);
    check("rst_a_data1", a_rd_data1, '0);
    check("rst_b_data1", b_rd_data1, '0);
    check("rst_a_data2", a_rd_data2, '0);
    check("rst_b_data2", b_rd_data2, '0);
    rst_next = 1'b1;

    // Read of addr 5 while filling is dropped; after fill it returns 0
    idle(2);
    issue(0, 1, '0, '0, '0, 1, 1, 6'd5, '0, '0);
    idle(DEPTH);
    rd_a(6'd5);
    idle(3);

    // Sequential writes on A, back-to-back reads on B
    for (int i = 0; i < 16; i++) wr_a(AW'(i), DW'(255 - i), 4'hF);
    for (int i = 0; i < 16; i++) issue(0, 1, '0, '0, '0, 1, 1, AW'(i), '0, '0);
    idle(3);

    // Partial byte-enable write
    wr_a(6'd3, 32'hAABBCCDD, 4'hF);
    wr_a(6'd3, 32'h11223344, 4'b0101);
    rd_a(6'd3);
    idle(3);

    // Same-cycle dual write with overlapping enables
    issue(1, 0, 6'd7, 4'b0011, 32'h0000FFFF, 1, 0, 6'd7, 4'b0110, 32'h12345678);
    rd_a(6'd7);
    idle(3);

    // Read/write collision both ways, then read/read
    wr_a(6'd9, 32'd1, 4'hF);
    issue(1, 1, 6'd9, '0, '0, 1, 0, 6'd9, 4'hF, 32'd2);
    issue(1, 0, 6'd9, 4'b1001, 32'hA5A5A5A5, 1, 1, 6'd9, '0, '0);
    issue(1, 1, 6'd9, '0, '0, 1, 1, 6'd9, '0, '0);
    idle(3);

    // Randomized traffic over a small address window to force collisions
    for (int i = 0; i < 400; i++) begin
      issue($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
            4'($urandom), $urandom,
            $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, AW'($urandom_range(0, 15)),
            4'($urandom), $urandom);
    end
    idle(3);

    // Reset in RUN with reads in flight: dut2's reads must never surface
    issue(1, 1, 6'd3, '0, '0, 1, 1, 6'd4, '0, '0);
    rst_next = 1'b0;
    idle(1);
    rst_next = 1'b1;
    idle(DEPTH / 2);
    // Reset halfway through the fill with a (dropped) read presented
    rd_a(6'd3);
    rst_next = 1'b0;
    idle(2);
    rst_next = 1'b1;
    idle(DEPTH + 2);
    rd_a(6'd3);
    rd_a(6'd7);
    idle(4);

    for (int k = 0; k < 4; k++) check($sformatf("drain_q%0d", k), DW'(q[k].size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
